// File: rtl/mips_run_pkg.sv
// Shared types and elaboration helpers for the MIPS run controller.
// The optional trace buffer is enabled by defining MIPS_TRACE_EN.
package mips_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } run_state_e;

  // Ceiling log2, never below 1 so it can size a counter or index directly.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(val)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

  function automatic bit params_ok(input int unsigned aw, input int unsigned cw,
                                   input int unsigned rst_cycles, input int unsigned halt_stable,
                                   input int unsigned timeout_cycles, input int unsigned trace_depth);
    bit ok;
    ok = (aw >= 1) && (cw >= 1) && (rst_cycles >= 1) && (halt_stable >= 1) &&
         (timeout_cycles >= 2) && (trace_depth >= 2) &&
         ((trace_depth & (trace_depth - 1)) == 0);
    if ((cw < 32) && (longint'(timeout_cycles) >= (longint'(1) << cw))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mips_trace_buf.sv
// Circular PC trace buffer: oldest entry overwritten, read index 0 is the newest entry.
// Only instantiated when MIPS_TRACE_EN is defined.
module mips_trace_buf
  import mips_run_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                            clk_i,
  input  logic                            clr_i,
  input  logic                            we_i,
  input  logic [AW-1:0]                   wdata_i,
  input  logic [clog2(TRACE_DEPTH)-1:0]   rd_idx_i,
  output logic [AW-1:0]                   rd_data_o
);

  localparam int unsigned IW  = clog2(TRACE_DEPTH);
  localparam int unsigned CWD = IW + 1;

  logic [AW-1:0]  mem_q [TRACE_DEPTH];
  logic [IW-1:0]  wptr_q, wptr_d;
  logic [CWD-1:0] cnt_q, cnt_d;
  logic [IW-1:0]  rd_ptr;

  always_comb begin
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      cnt_d  = '0;
    end else if (we_i) begin
      wptr_d = wptr_q + IW'(1);
      if (cnt_q != CWD'(TRACE_DEPTH)) cnt_d = cnt_q + CWD'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    wptr_q <= wptr_d;
    cnt_q  <= cnt_d;
  end

  // Storage is deliberately not cleared; the valid count hides stale entries.
  always_ff @(posedge clk_i) begin
    if (we_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    rd_ptr    = wptr_q - IW'(1) - rd_idx_i;
    rd_data_o = '0;
    if ({1'b0, rd_idx_i} < cnt_q) rd_data_o = mem_q[rd_ptr];
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: core reset sequencing, cycle counting, halt/timeout detection.
// Define MIPS_TRACE_EN to add a circular trace of distinct PCs seen while running.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned CW             = 32,
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned HALT_STABLE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned TRACE_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          pc_rst,
  input  logic                          start,
  input  logic [AW-1:0]                 pc,
  input  logic [clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic                          cpu_rst,
  output logic                          running,
  output logic                          done,
  output logic                          timed_out,
  output logic [CW-1:0]                 cycle_cnt,
  output logic [AW-1:0]                 trace_pc
);

  localparam int unsigned RCW = clog2(RST_CYCLES);
  localparam int unsigned SCW = clog2(HALT_STABLE);

  if (!params_ok(AW, CW, RST_CYCLES, HALT_STABLE, TIMEOUT_CYCLES, TRACE_DEPTH)) begin : g_param_check
    $error("mips_run_ctrl: illegal parameter combination");
  end

  run_state_e     state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [SCW-1:0] stable_q, stable_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic           pc_vld_q, pc_vld_d;
  logic           done_q, done_d;
  logic           timed_out_q, timed_out_d;
  logic           enter_reset;
  logic           pc_eq;
  logic           halt_hit;
  logic           timeout_hit;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stable_d    = stable_q;
    pc_d        = pc_q;
    pc_vld_d    = pc_vld_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    enter_reset = 1'b0;
    pc_eq       = pc_vld_q && (pc == pc_q);
    halt_hit    = pc_eq && (stable_q == SCW'(HALT_STABLE - 1));
    timeout_hit = (cycle_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (start) enter_reset = 1'b1;
      end
      ST_RESET: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = ST_RUN;
        else                                   rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CW'(1);
        pc_d        = pc;
        pc_vld_d    = 1'b1;
        if (pc_vld_q) stable_d = pc_eq ? stable_q + SCW'(1) : '0;
        // Halt is checked first so a same-cycle halt and timeout reports only done.
        if (halt_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d     = ST_TIMEOUT;
          timed_out_d = 1'b1;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (start) enter_reset = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_reset) begin
      state_d     = ST_RESET;
      rst_cnt_d   = '0;
      cycle_cnt_d = '0;
      stable_d    = '0;
      pc_vld_d    = 1'b0;
      done_d      = 1'b0;
      timed_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pc_rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      stable_q    <= '0;
      pc_q        <= '0;
      pc_vld_q    <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stable_q    <= stable_d;
      pc_q        <= pc_d;
      pc_vld_q    <= pc_vld_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign cpu_rst   = (state_q == ST_IDLE) || (state_q == ST_RESET);
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign cycle_cnt = cycle_cnt_q;

`ifdef MIPS_TRACE_EN
  logic trace_we;
  logic trace_clr;

  assign trace_we  = !pc_rst && (state_q == ST_RUN) && (!pc_vld_q || (pc != pc_q));
  assign trace_clr = pc_rst || enter_reset;

  mips_trace_buf #(
    .AW          (AW),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_buf (
    .clk_i     (clk),
    .clr_i     (trace_clr),
    .we_i      (trace_we),
    .wdata_i   (pc),
    .rd_idx_i  (trace_idx),
    .rd_data_o (trace_pc)
  );
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: vector table plus scoreboard queue of expected outputs.
module tb_mips_run_ctrl;

  localparam int AW = 32;
  localparam int CW = 32;
  localparam int TD = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          pc_rst;
  logic          start;
  logic [AW-1:0] pc;
  logic [IW-1:0] trace_idx;
  logic          cpu_rst;
  logic          running;
  logic          done;
  logic          timed_out;
  logic [CW-1:0] cycle_cnt;
  logic [AW-1:0] trace_pc;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .AW             (AW),
    .CW             (CW),
    .RST_CYCLES     (2),
    .HALT_STABLE    (4),
    .TIMEOUT_CYCLES (500),
    .TRACE_DEPTH    (TD)
  ) dut (
    .clk       (clk),
    .pc_rst    (pc_rst),
    .start     (start),
    .pc        (pc),
    .trace_idx (trace_idx),
    .cpu_rst   (cpu_rst),
    .running   (running),
    .done      (done),
    .timed_out (timed_out),
    .cycle_cnt (cycle_cnt),
    .trace_pc  (trace_pc)
  );

  typedef struct {
    logic          rst;
    logic          st;
    logic [AW-1:0] pcv;
    logic          e_cpu_rst;
    logic          e_run;
    logic          e_done;
    logic          e_to;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rst, input logic st, input logic [AW-1:0] pcv,
                              input logic cr, input logic rn, input logic dn, input logic to,
                              input logic [CW-1:0] cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.pcv = pcv;
    v.e_cpu_rst = cr; v.e_run = rn; v.e_done = dn; v.e_to = to; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    pc_rst = v.rst;
    start  = v.st;
    pc     = v.pcv;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, " cpu_rst"},   {31'd0, cpu_rst},   {31'd0, e.e_cpu_rst});
      chk({tag, " running"},   {31'd0, running},   {31'd0, e.e_run});
      chk({tag, " done"},      {31'd0, done},      {31'd0, e.e_done});
      chk({tag, " timed_out"}, {31'd0, timed_out}, {31'd0, e.e_to});
      chk({tag, " cycle_cnt"}, cycle_cnt,          e.e_cnt);
    end
  endtask

  task automatic tchk(input logic [IW-1:0] idx, input logic [AW-1:0] exp_on, input string tag);
    trace_idx = idx;
    #1;
`ifdef MIPS_TRACE_EN
    chk(tag, trace_pc, exp_on);
`else
    chk(tag, trace_pc, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    pc_rst    = 1'b1;
    start     = 1'b0;
    pc        = '0;
    trace_idx = '0;

    // Reset, start, 2-cycle core reset, halt on jump-to-self, restart, starts ignored, mid-run reset.
    tbl.push_back(mk(1, 0, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h4,   0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 32'h8,   0, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 32'hC,   0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 32'hC,   0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 0, 32'hC,   0, 1, 0, 0, 6));
    tbl.push_back(mk(0, 0, 32'hC,   0, 1, 0, 0, 7));
    tbl.push_back(mk(0, 0, 32'hC,   0, 0, 1, 0, 8));
    tbl.push_back(mk(0, 0, 32'hC,   0, 0, 1, 0, 8));
    tbl.push_back(mk(0, 1, 32'hC,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hC,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hC,   0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h104, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 32'h108, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Timeout with a PC that never repeats.
    for (int k = 1; k <= 500; k++)
      step(mk(0, 0, 32'(4 * k), 0, (k < 500), 0, (k == 500), 32'(k)), $sformatf("to%0d", k));
    step(mk(0, 0, 32'h9999, 0, 0, 0, 1, 500), "to_frozen");

    // Restart from TIMEOUT, then halt and timeout land on the same edge.
    step(mk(0, 1, 32'h0, 1, 0, 0, 0, 0), "rs0");
    step(mk(0, 0, 32'h0, 1, 0, 0, 0, 0), "rs1");
    step(mk(0, 0, 32'h0, 0, 1, 0, 0, 0), "rs2");
    for (int k = 1; k <= 500; k++)
      step(mk(0, 0, (k <= 496) ? 32'(4 * k) : 32'(4 * 496), 0, (k < 500), (k == 500), 0, 32'(k)),
           $sformatf("ht%0d", k));
    step(mk(0, 0, 32'h0, 0, 0, 1, 0, 500), "ht_frozen");

    // Trace run from a clean reset.
    step(mk(1, 0, 32'h0, 1, 0, 0, 0, 0), "tr_rst");
    step(mk(0, 1, 32'h0, 1, 0, 0, 0, 0), "tr_st");
    step(mk(0, 0, 32'h0, 1, 0, 0, 0, 0), "tr_r1");
    step(mk(0, 0, 32'h0, 0, 1, 0, 0, 0), "tr_r2");
    for (int k = 0; k < 3; k++)
      step(mk(0, 0, 32'(4 * k), 0, 1, 0, 0, 32'(k + 1)), $sformatf("tr%0d", k));
    tchk(3'd0, 32'h08, "trace3_idx0");
    tchk(3'd2, 32'h00, "trace3_idx2");
    tchk(3'd3, 32'h00, "trace3_idx3");
    tchk(3'd7, 32'h00, "trace3_idx7");
    for (int k = 3; k < 10; k++)
      step(mk(0, 0, 32'(4 * k), 0, 1, 0, 0, 32'(k + 1)), $sformatf("tr%0d", k));
    tchk(3'd0, 32'h24, "trace10_idx0");
    tchk(3'd3, 32'h18, "trace10_idx3");
    tchk(3'd7, 32'h08, "trace10_idx7");
    trace_idx = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
